// File: rtl/sysid_boot_checker.sv
// Boot-time reader for the sysid slave: reads the ID and build timestamp words over Avalon-MM and flags mismatches or a stalled slave.
// Optional build macro SYSID_CHECK_RETRY_EN: re-runs a failed check up to three more times before reporting.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5510_A822,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

`ifdef SYSID_CHECK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        addr_q, addr_d;
  logic        read_q, read_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_q, stall_d;
  logic [1:0]  retry_q, retry_d;

  logic        accept_s;
  logic        expired_s;
  logic [15:0] stall_inc_s;
  logic        finish_s;
  logic        fin_to_s;
  logic        fin_id_ok_s;
  logic        fin_ts_ok_s;

  // Next-state and next-output computation for the read sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    id_d        = id_q;
    ts_d        = ts_q;
    done_d      = done_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    stall_d     = stall_q;
    retry_d     = retry_q;
    finish_s    = 1'b0;
    fin_to_s    = 1'b0;
    fin_id_ok_s = 1'b0;
    fin_ts_ok_s = 1'b0;

    accept_s    = read_q && !avm_waitrequest;
    stall_inc_s = (stall_q == 16'hFFFF) ? stall_q : (stall_q + 16'd1);
    // An accepted read means no stall this cycle, so it always wins over expiry.
    expired_s   = read_q && avm_waitrequest && (stall_inc_s >= TIMEOUT_LIMIT);

    case (state_q)
      IDLE, DONE: begin
        if ((state_q == IDLE) || start) begin
          state_d   = RD_ID;
          read_d    = 1'b1;
          addr_d    = 1'b0;
          stall_d   = 16'd0;
          done_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          retry_d   = 2'd0;
        end else begin
          read_d = 1'b0;
        end
      end
      RD_ID: begin
        if (accept_s) begin
          id_d    = avm_readdata;
          state_d = RD_TS;
          addr_d  = 1'b1;
          stall_d = 16'd0;
        end else if (expired_s) begin
          finish_s = 1'b1;
          fin_to_s = 1'b1;
        end else begin
          stall_d = stall_inc_s;
        end
      end
      RD_TS: begin
        if (accept_s) begin
          ts_d        = avm_readdata;
          finish_s    = 1'b1;
          fin_id_ok_s = (id_q == EXPECTED_ID);
          fin_ts_ok_s = (avm_readdata == EXPECTED_TIMESTAMP);
        end else if (expired_s) begin
          finish_s    = 1'b1;
          fin_to_s    = 1'b1;
          fin_id_ok_s = (id_q == EXPECTED_ID);
        end else begin
          stall_d = stall_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        addr_d  = 1'b0;
        stall_d = 16'd0;
      end
    endcase

    if (finish_s) begin
      if (RETRY_EN && (fin_to_s || !fin_id_ok_s || !fin_ts_ok_s) && (retry_q != 2'd3)) begin
        retry_d = retry_q + 2'd1;
        state_d = RD_ID;
        read_d  = 1'b1;
        addr_d  = 1'b0;
        stall_d = 16'd0;
      end else begin
        state_d   = DONE;
        read_d    = 1'b0;
        addr_d    = 1'b0;
        stall_d   = 16'd0;
        done_d    = 1'b1;
        id_ok_d   = fin_id_ok_s;
        ts_ok_d   = fin_ts_ok_s;
        timeout_d = fin_to_s;
      end
    end else begin
      retry_d = retry_d;
    end
  end

  // State and output registers; reset aborts any read in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      id_q      <= 32'd0;
      ts_q      <= 32'd0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      stall_q   <= 16'd0;
      retry_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      done_q    <= done_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      retry_q   <= retry_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: a stalling slave model serves planned or random reads,
// a transaction-level model predicts the outcome and completion cycle of each check sequence.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'hC0DE_1234;
  localparam logic [31:0] EXP_TS = 32'h5510_A822;
  localparam int T = 8;
`ifdef SYSID_CHECK_RETRY_EN
  localparam int MAX_ATT = 4;
`else
  localparam int MAX_ATT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_address, avm_read, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .id_value(id_value),
    .ts_value(ts_value),
    .done(done),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          stall;
    logic [31:0] data;
    logic        addr;
  } rd_t;

  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] id_v;
    logic [31:0] ts_v;
    int          cyc;
  } exp_t;

  rd_t  plan_q[$];
  rd_t  resp_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave bookkeeping at the clock edge, using the values present during the finished cycle.
  bit   slv_busy = 1'b0;
  rd_t  slv_cur;
  int   slv_cnt = 0;
  bit   hold_chk = 1'b0;
  logic hold_addr = 1'b0;

  always @(posedge clock) begin
    cyc++;
    hold_chk = 1'b0;
    if (reset) begin
      slv_busy = 1'b0;
    end else if (slv_busy && avm_read) begin
      if (!avm_waitrequest) begin
        slv_busy = 1'b0;
      end else begin
        slv_cnt++;
        if (slv_cnt >= T) begin
          slv_busy = 1'b0;
        end else begin
          hold_chk  = 1'b1;
          hold_addr = avm_address;
        end
      end
    end
  end

  // Slave response drive, mid-cycle.
  always @(negedge clock) begin
    if (hold_chk && !reset) begin
      check("hold_read", avm_read, 1);
      check("hold_addr", avm_address, hold_addr);
    end
    if (!slv_busy && avm_read && !reset) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got read at address %0d, expected no read", avm_address);
        slv_cur = '{stall: 0, data: 32'hDEAD_BEEF, addr: avm_address};
      end else begin
        slv_cur = resp_q.pop_front();
      end
      check("rd_addr", avm_address, slv_cur.addr);
      slv_busy = 1'b1;
      slv_cnt  = 0;
    end
    avm_waitrequest = slv_busy && (slv_cnt < slv_cur.stall);
    avm_readdata    = (slv_busy && !avm_waitrequest) ? slv_cur.data : $urandom();
  end

  // Monitor: flags must stay low outside DONE; each rise of done is scored against the model.
  logic done_prev = 1'b0;
  exp_t e;
  always @(negedge clock) begin
    if (!reset) begin
      if (!done) begin
        check("flags_not_done", {id_ok, ts_ok, timeout}, 0);
      end else if (!done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("id_ok", id_ok, e.id_ok);
          check("ts_ok", ts_ok, e.ts_ok);
          check("timeout", timeout, e.to);
          check("id_value", id_value, e.id_v);
          check("ts_value", ts_value, e.ts_v);
          check("read_off_at_done", avm_read, 0);
        end
      end
    end
    done_prev = done;
  end

  task automatic next_read(input logic a, output rd_t r);
    if (plan_q.size() > 0) begin
      r = plan_q.pop_front();
    end else begin
      r.stall = ($urandom_range(0, 9) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 3);
      r.data  = ($urandom_range(0, 3) == 0) ? $urandom() : (a ? EXP_TS : EXP_ID);
    end
    r.addr = a;
    resp_q.push_back(r);
  endtask

  // Outcome of one check sequence whose first read starts at clock edge e0.
  task automatic model_seq(input int e0);
    int   t   = e0;
    int   att = 0;
    bit   pass;
    exp_t x;
    rd_t  r;
    do begin
      x.to = 1'b0; x.id_ok = 1'b0; x.ts_ok = 1'b0;
      next_read(1'b0, r);
      if (r.stall >= T) begin
        t += T;
        x.to = 1'b1;
      end else begin
        t += r.stall + 1;
        m_id = r.data;
        x.id_ok = (m_id == EXP_ID);
        next_read(1'b1, r);
        if (r.stall >= T) begin
          t += T;
          x.to = 1'b1;
        end else begin
          t += r.stall + 1;
          m_ts = r.data;
          x.ts_ok = (m_ts == EXP_TS);
        end
      end
      pass = !x.to && x.id_ok && x.ts_ok;
      att++;
    end while (!pass && att < MAX_ATT);
    x.id_v = m_id;
    x.ts_v = m_ts;
    x.cyc  = t;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s: done=0 after 200 cycles, expected done=1", name);
    end
  endtask

  task automatic do_start(input string name, input bit mid_pulse);
    @(negedge clock);
    start = 1'b1;
    model_seq(cyc + 1);
    @(negedge clock);
    start = 1'b0;
    if (mid_pulse) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_read"}, avm_read, 0);
    check({name, "_addr"}, avm_address, 0);
    check({name, "_id"}, id_value, 0);
    check({name, "_ts"}, ts_value, 0);
    check({name, "_done"}, done, 0);
    check({name, "_flags"}, {id_ok, ts_ok, timeout}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    repeat (2) @(negedge clock);
    check_all_zero("reset");

    // Boot check with a zero-wait slave.
    plan_q.push_back('{stall: 0, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: EXP_TS, addr: 1'b1});
    model_seq(cyc + 1);
    rel = cyc;
    reset = 1'b0;
    wait_done("boot");
    check("boot_latency", cyc - rel, 3);

    // Four stall cycles on the timestamp read.
    plan_q.push_back('{stall: 0, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 4, data: EXP_TS, addr: 1'b1});
    do_start("ts_stall4", 1'b0);

    // Slave stuck on the ID read.
    plan_q.push_back('{stall: 50, data: EXP_ID, addr: 1'b0});
    do_start("id_timeout", 1'b0);
    check("id_timeout_flag", timeout, 1);

    // Zero timestamp, then a clean rerun.
    plan_q.push_back('{stall: 0, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: 32'h0, addr: 1'b1});
    do_start("ts_zero", 1'b0);
    plan_q.push_back('{stall: 0, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: EXP_TS, addr: 1'b1});
    do_start("rerun_ok", 1'b0);
    check("rerun_ts_ok", ts_ok, 1);

    // Reset in the middle of a stalled timestamp read.
    plan_q.push_back('{stall: 0, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 6, data: EXP_TS, addr: 1'b1});
    @(negedge clock);
    start = 1'b1;
    model_seq(cyc + 1);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_reset_ts_read", {avm_read, avm_address}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    resp_q.delete();
    plan_q.delete();
    m_id = 32'd0;
    m_ts = 32'd0;
    repeat (2) @(negedge clock);
    plan_q.push_back('{stall: 1, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: EXP_TS, addr: 1'b1});
    model_seq(cyc + 1);
    reset = 1'b0;
    wait_done("post_reset_boot");

`ifdef SYSID_CHECK_RETRY_EN
    // Wrong ID twice, then correct.
    plan_q.push_back('{stall: 0, data: 32'h1111_0000, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: EXP_TS, addr: 1'b1});
    plan_q.push_back('{stall: 0, data: 32'h2222_0000, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: EXP_TS, addr: 1'b1});
    plan_q.push_back('{stall: 0, data: EXP_ID, addr: 1'b0});
    plan_q.push_back('{stall: 0, data: EXP_TS, addr: 1'b1});
    do_start("retry_id", 1'b0);
    check("retry_id_ok", id_ok, 1);
`endif

    // Randomized sequences, some with a start pulse mid-sequence that must be ignored.
    for (int i = 0; i < 40; i++) begin
      do_start("random", ($urandom_range(0, 2) == 0));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
